// File: rtl/bpred_init_if.sv
// Predictor/RF init bus: EX-side update requests in, table write ports out.
// master = update source and table owner, slave = init sequencer.
interface bpred_init_if #(
    parameter int BTB_AW = 8,
    parameter int BTB_W  = 40,
    parameter int BHT_AW = 8,
    parameter int RF_AW  = 5
);
    logic              pred_flush_i;
    logic              btb_upd_i;
    logic [BTB_AW-1:0] btb_upd_addr_i;
    logic [BTB_W-1:0]  btb_upd_data_i;
    logic              bht_upd_i;
    logic [BHT_AW-1:0] bht_upd_addr_i;
    logic [1:0]        bht_upd_data_i;

    logic              btb_we_o;
    logic [BTB_AW-1:0] btb_waddr_o;
    logic [BTB_W-1:0]  btb_wdata_o;
    logic              bht_we_o;
    logic [BHT_AW-1:0] bht_waddr_o;
    logic [1:0]        bht_wdata_o;
    logic              rf_we_o;
    logic [RF_AW-1:0]  rf_waddr_o;
    logic [31:0]       rf_wdata_o;
    logic              stall_o;
    logic              init_done_o;
    logic              upd_drop_o;

    modport master (
        output pred_flush_i, btb_upd_i, btb_upd_addr_i, btb_upd_data_i,
        output bht_upd_i, bht_upd_addr_i, bht_upd_data_i,
        input  btb_we_o, btb_waddr_o, btb_wdata_o,
        input  bht_we_o, bht_waddr_o, bht_wdata_o,
        input  rf_we_o, rf_waddr_o, rf_wdata_o,
        input  stall_o, init_done_o, upd_drop_o
    );

    modport slave (
        input  pred_flush_i, btb_upd_i, btb_upd_addr_i, btb_upd_data_i,
        input  bht_upd_i, bht_upd_addr_i, bht_upd_data_i,
        output btb_we_o, btb_waddr_o, btb_wdata_o,
        output bht_we_o, bht_waddr_o, bht_wdata_o,
        output rf_we_o, rf_waddr_o, rf_wdata_o,
        output stall_o, init_done_o, upd_drop_o
    );
endinterface

// File: rtl/bpred_init_ctrl.sv
// Clears BTB/BHT/RF after reset, stalls the pipe meanwhile, then arbitrates
// the BTB/BHT write ports between EX updates and run-time predictor flushes.
module bpred_init_ctrl #(
    parameter int           BTB_AW   = 8,
    parameter int           BTB_W    = 40,
    parameter int           BHT_AW   = 8,
    parameter int           RF_AW    = 5,
    parameter logic [1:0]   BHT_INIT = 2'b00
) (
    input  logic        clk,
    input  logic        rst_i,
    bpred_init_if.slave bus
);

    localparam logic [1:0] SWEEP_ALL  = 2'd0;
    localparam logic [1:0] RUN        = 2'd1;
    localparam logic [1:0] SWEEP_PRED = 2'd2;

    logic [1:0]        state;
    logic [BTB_AW-1:0] idx;
    logic              last;
    logic              rf_span;
    logic              any_upd;

    assign last    = (idx == {BTB_AW{1'b1}});
    assign rf_span = (idx[BTB_AW-1:RF_AW] == '0);
    assign any_upd = bus.btb_upd_i | bus.bht_upd_i;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state           <= SWEEP_ALL;
            idx             <= '0;
            bus.btb_we_o    <= 1'b0;
            bus.btb_waddr_o <= '0;
            bus.btb_wdata_o <= '0;
            bus.bht_we_o    <= 1'b0;
            bus.bht_waddr_o <= '0;
            bus.bht_wdata_o <= '0;
            bus.rf_we_o     <= 1'b0;
            bus.rf_waddr_o  <= '0;
            bus.rf_wdata_o  <= '0;
            bus.stall_o     <= 1'b1;
            bus.init_done_o <= 1'b0;
            bus.upd_drop_o  <= 1'b0;
        end else begin
            bus.rf_we_o    <= 1'b0;
            bus.rf_wdata_o <= '0;
            case (state)
                RUN: begin
                    bus.init_done_o <= 1'b1;
                    if (bus.pred_flush_i) begin
                        // Flush outranks any update arriving in the same cycle.
                        state          <= SWEEP_PRED;
                        idx            <= '0;
                        bus.btb_we_o   <= 1'b0;
                        bus.bht_we_o   <= 1'b0;
                        bus.stall_o    <= 1'b1;
                        bus.upd_drop_o <= any_upd;
                    end else begin
                        bus.btb_we_o    <= bus.btb_upd_i;
                        bus.btb_waddr_o <= bus.btb_upd_addr_i;
                        bus.btb_wdata_o <= bus.btb_upd_data_i;
                        bus.bht_we_o    <= bus.bht_upd_i;
                        bus.bht_waddr_o <= bus.bht_upd_addr_i;
                        bus.bht_wdata_o <= bus.bht_upd_data_i;
                        bus.stall_o     <= 1'b0;
                        bus.upd_drop_o  <= 1'b0;
                    end
                end
                SWEEP_ALL, SWEEP_PRED: begin
                    bus.btb_we_o    <= 1'b1;
                    bus.btb_waddr_o <= idx;
                    bus.btb_wdata_o <= '0;
                    bus.bht_we_o    <= 1'b1;
                    bus.bht_waddr_o <= idx;
                    bus.bht_wdata_o <= BHT_INIT;
                    bus.rf_we_o     <= (state == SWEEP_ALL) && rf_span;
                    bus.rf_waddr_o  <= idx[RF_AW-1:0];
                    bus.stall_o     <= 1'b1;
                    bus.upd_drop_o  <= any_upd;
                    if (last) begin
                        state <= RUN;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state           <= SWEEP_ALL;
                    idx             <= '0;
                    bus.btb_we_o    <= 1'b0;
                    bus.bht_we_o    <= 1'b0;
                    bus.stall_o     <= 1'b1;
                    bus.init_done_o <= 1'b0;
                    bus.upd_drop_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/bpred_init_ctrl.md
Name: bpred_init_ctrl

Overview:
Sequencer and write-port arbiter for the branch predictor tables (BTB, BHT) and the register file.
- After reset it sweeps every BTB/BHT entry and every RF entry with clear values.
- It holds the pipeline in stall until the sweep completes.
- It then grants the BTB/BHT write ports to the EX-stage update logic.
- A predictor flush request re-runs the BTB/BHT sweep at run time without touching the RF.

Parameters:
BTB_AW, 8, BTB index width (depth 2^BTB_AW = 256)
BTB_W, 40, BTB entry width
BHT_AW, 8, BHT index width; must equal BTB_AW
RF_AW, 5, register file index width (32 entries)
BHT_INIT, 2'b00, counter value written to every BHT entry during a sweep

Ports:
clk  in  1  clock
rst_i  in  1  synchronous active-high reset
pred_flush_i  in  1  request predictor-only sweep (level, sampled in RUN)
btb_upd_i  in  1  BTB update request from EX
btb_upd_addr_i  in  BTB_AW  BTB update index
btb_upd_data_i  in  BTB_W  BTB update entry
bht_upd_i  in  1  BHT update request from EX
bht_upd_addr_i  in  BHT_AW  BHT update index
bht_upd_data_i  in  2  BHT update counter
btb_we_o  out  1  BTB write enable
btb_waddr_o  out  BTB_AW  BTB write index
btb_wdata_o  out  BTB_W  BTB write data
bht_we_o  out  1  BHT write enable
bht_waddr_o  out  BHT_AW  BHT write index
bht_wdata_o  out  2  BHT write data
rf_we_o  out  1  RF init write enable
rf_waddr_o  out  RF_AW  RF init index
rf_wdata_o  out  32  RF init data (always 0)
stall_o  out  1  pipeline hold; high while any sweep is active
init_done_o  out  1  set after the first full sweep completes; cleared only by reset
upd_drop_o  out  1  one-cycle pulse: an update request was discarded

Behaviour:
- All outputs are registered. Every write-port output appears one cycle after the state/index that produces it.
- Reset: rst_i high at an edge sets state=SWEEP_ALL and idx=0. Outputs on reset: all *_we_o=0, addrs/data=0, stall_o=1, init_done_o=0, upd_drop_o=0.
- The reset value applies from any state. Reset mid-sweep restarts the sweep at idx 0.
- States: SWEEP_ALL, RUN, SWEEP_PRED.
- SWEEP_ALL, each cycle:
  - btb_we=1, addr=idx, data=0.
  - bht_we=1, addr=idx, data=BHT_INIT.
  - rf_we=1, addr=idx[RF_AW-1:0], data=0, only while idx < 32.
  - idx increments. At idx==255 (terminal detect on equality, no wrap compare), go to RUN with idx=0.
  - Result: exactly 256 BTB/BHT writes (addr 0..255) and 32 RF writes (addr 0..31).
- stall_o stays 1 through the output cycle of the last write. It falls the following cycle. init_done_o rises in that same cycle.
- RUN:
  - stall_o=0.
  - btb_upd_i is registered onto the BTB write port (1-cycle latency, addr/data passed through).
  - bht_upd_i is registered onto the BHT write port independently.
  - rf_we_o=0.
- RUN with pred_flush_i=1: enter SWEEP_PRED with idx=0.
  - Flush wins over any same-cycle update.
  - That update is dropped and upd_drop_o pulses.
- SWEEP_PRED:
  - Same as SWEEP_ALL except rf_we_o=0.
  - stall_o=1; init_done_o stays 1.
  - At idx==255, return to RUN.
- Updates arriving in either sweep state are dropped: no write occurs and upd_drop_o=1 for each such cycle.
- pred_flush_i during a sweep is ignored; it is not queued.
- idx is BTB_AW bits. It never wraps within a sweep.
- BTB and BHT updates in the same RUN cycle are both honoured; the ports are independent.

Test Plan:
- Reset 2 cycles then release:
  - btb_we_o/bht_we_o high for exactly 256 consecutive cycles, addr 0..255, btb data 0, bht data BHT_INIT.
  - rf_we_o high for the first 32 of those cycles, addr 0..31.
  - stall_o falls and init_done_o rises on the cycle after addr 255.
- RUN, btb_upd_i=1, addr=8'h3C, data=40'h12_3456_789A:
  - next cycle btb_we_o=1, btb_waddr_o=3C, btb_wdata_o=12_3456_789A.
  - stall_o=0, upd_drop_o=0.
- bht_upd_i=1 at sweep idx 100: no extra BHT write at that index, upd_drop_o=1 next cycle, sweep sequence unbroken.
- RUN, pred_flush_i=1 together with btb_upd_i=1:
  - upd_drop_o pulses.
  - 256-cycle BTB/BHT sweep with rf_we_o=0 throughout.
  - stall_o=1 during the sweep; init_done_o stays 1.
  - Return to RUN afterwards.
- rst_i asserted at sweep idx 150 for 1 cycle: outputs return to reset values, then a full sweep restarts from addr 0 including RF writes, and init_done_o=0 until it completes.
- pred_flush_i held high through SWEEP_PRED: no second sweep starts until RUN is re-entered. If still high in RUN, exactly one new sweep starts.
